// File: rtl/rv32i_fetch_stage_if.sv
// Fetch-stage connections: instruction memory port, branch predictor,
// execute-stage control and the fetch->execute pipeline register.
interface rv32i_fetch_stage_if;
    localparam int unsigned W = 32;

    // instruction memory port
    logic         imem_ren;
    logic [W-1:0] imem_addr;
    logic [W-1:0] imem_rdata;
    logic         imem_busy;

    // branch predictor lookup for the current PC
    logic         predict_taken;
    logic [W-1:0] predict_target;

    // execute-stage control
    logic         ex_stall;
    logic         ex_flush;
    logic [W-1:0] ex_redirect_pc;

    // status and fetch->execute pipeline register
    logic         fetch_misaligned;
    logic         fe_token;
    logic [W-1:0] fe_pc;
    logic [W-1:0] fe_pc4;
    logic [W-1:0] fe_instr;
    logic [W-1:0] fe_prediction;

    // fetch-stage side
    modport master (
        output imem_ren, imem_addr, fetch_misaligned,
               fe_token, fe_pc, fe_pc4, fe_instr, fe_prediction,
        input  imem_rdata, imem_busy, predict_taken, predict_target,
               ex_stall, ex_flush, ex_redirect_pc
    );

    // memory / predictor / execute side
    modport slave (
        input  imem_ren, imem_addr, fetch_misaligned,
               fe_token, fe_pc, fe_pc4, fe_instr, fe_prediction,
        output imem_rdata, imem_busy, predict_taken, predict_target,
               ex_stall, ex_flush, ex_redirect_pc
    );
endinterface

// File: rtl/rv32i_fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, issues word fetches, applies
// the predictor's next-PC choice, redirects on execute flushes and drops any
// in-flight fetch made stale by a redirect.
module rv32i_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0200,
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    rv32i_fetch_stage_if.master bus
);
    localparam int unsigned W = WORD_SIZE;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t       state;
    logic [W-1:0] pc;
    logic [W-1:0] discard_addr;
    logic         misaligned;
    logic         token;
    logic [W-1:0] held_pc;
    logic [W-1:0] held_pc4;
    logic [W-1:0] held_instr;
    logic [W-1:0] held_prediction;

    logic [W-1:0] pc4_c;
    logic [W-1:0] prediction_c;
    logic [W-1:0] addr_c;
    logic         accept_c;

    // next-PC candidates and the accept condition for the current fetch
    always_comb begin
        pc4_c        = pc + W'(4);
        prediction_c = bus.predict_taken ? bus.predict_target : pc4_c;
        addr_c       = (state == DISCARD) ? discard_addr : pc;
        accept_c     = (state == FETCH) && !misaligned && !bus.imem_busy
                       && !bus.ex_stall && !bus.ex_flush;
    end

    // memory request: an outstanding stale fetch keeps its old address;
    // a misaligned PC stops requesting; nothing is requested in reset
    assign bus.imem_ren  = nRST && ((state == DISCARD) || !misaligned);
    assign bus.imem_addr = addr_c;

    assign bus.fetch_misaligned = misaligned;
    assign bus.fe_token         = token;
    assign bus.fe_pc            = held_pc;
    assign bus.fe_pc4           = held_pc4;
    assign bus.fe_instr         = held_instr;
    assign bus.fe_prediction    = held_prediction;

    // fetch FSM, PC and pipeline register; flush outranks everything
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            discard_addr    <= '0;
            misaligned      <= 1'b0;
            token           <= 1'b0;
            held_pc         <= '0;
            held_pc4        <= '0;
            held_instr      <= '0;
            held_prediction <= '0;
        end else if (bus.ex_flush) begin
            token        <= 1'b0;
            pc           <= bus.ex_redirect_pc;
            misaligned   <= (bus.ex_redirect_pc[1:0] != 2'b00);
            discard_addr <= addr_c;
            state        <= bus.imem_busy ? DISCARD : FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (accept_c) begin
                        token           <= 1'b1;
                        held_pc         <= pc;
                        held_pc4        <= pc4_c;
                        held_instr      <= bus.imem_rdata;
                        held_prediction <= prediction_c;
                        pc              <= prediction_c;
                    end else if (!bus.ex_stall) begin
                        token <= 1'b0;
                    end
                end
                DISCARD: begin
                    // stale data returns this cycle and is dropped
                    if (!bus.imem_busy) begin
                        state <= FETCH;
                    end
                    if (!bus.ex_stall) begin
                        token <= 1'b0;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_fetch_stage.sv
// Bench for rv32i_fetch_stage: directed test-plan scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_rv32i_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0200;

    logic clk = 1'b0;
    logic nrst;

    rv32i_fetch_stage_if bus ();

    rv32i_fetch_stage #(
        .RESET_PC (RESET_PC),
        .WORD_SIZE(32)
    ) dut (
        .CLK (clk),
        .nRST(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // stimulus for the next clock edge
    logic        s_busy, s_stall, s_flush, s_taken, s_ovr_en;
    logic [31:0] s_rpc, s_tgt, s_ovr;

    // reference model state
    logic        m_disc, m_mis, m_tok;
    logic [31:0] m_pc, m_daddr, m_fpc, m_fpc4, m_finstr, m_fpred;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_disc = 1'b0; m_mis = 1'b0; m_tok = 1'b0;
        m_pc = RESET_PC; m_daddr = '0;
        m_fpc = '0; m_fpc4 = '0; m_finstr = '0; m_fpred = '0;
    endtask

    // one clock of the fetch rules, using the inputs seen at the edge
    task automatic model_step(input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        if (s_flush) begin
            m_tok   = 1'b0;
            m_daddr = a;
            m_disc  = s_busy;
            m_pc    = s_rpc;
            m_mis   = (s_rpc[1:0] != 2'b00);
        end else if (m_disc) begin
            if (!s_busy)  m_disc = 1'b0;
            if (!s_stall) m_tok  = 1'b0;
        end else if (!m_mis && !s_busy && !s_stall) begin
            m_tok    = 1'b1;
            m_fpc    = m_pc;
            m_fpc4   = p4;
            m_finstr = rd;
            m_fpred  = s_taken ? s_tgt : p4;
            m_pc     = m_fpred;
        end else if (!s_stall) begin
            m_tok = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic        eren;
        logic [31:0] eaddr;
        eren  = nrst && (m_disc || !m_mis);
        eaddr = m_disc ? m_daddr : m_pc;
        check("imem_ren",   32'(bus.imem_ren), 32'(eren));
        check("imem_addr",  bus.imem_addr, eaddr);
        check("misaligned", 32'(bus.fetch_misaligned), 32'(m_mis));
        check("fe_token",   32'(bus.fe_token), 32'(m_tok));
        check("fe_pc",      bus.fe_pc, m_fpc);
        check("fe_pc4",     bus.fe_pc4, m_fpc4);
        check("fe_instr",   bus.fe_instr, m_finstr);
        check("fe_pred",    bus.fe_prediction, m_fpred);
    endtask

    // apply stimulus, clock once, advance the model and compare
    task automatic tick();
        logic [31:0] a, rd;
        a = m_disc ? m_daddr : m_pc;
        rd = s_busy ? $urandom() : (s_ovr_en ? s_ovr : mem_word(a));
        bus.imem_busy      = s_busy;
        bus.ex_stall       = s_stall;
        bus.ex_flush       = s_flush;
        bus.ex_redirect_pc = s_rpc;
        bus.predict_taken  = s_taken;
        bus.predict_target = s_tgt;
        bus.imem_rdata     = rd;
        @(posedge clk);
        model_step(a, rd);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic busy, input logic stall, input logic flush,
                         input logic [31:0] rpc, input logic taken, input logic [31:0] tgt);
        s_busy = busy; s_stall = stall; s_flush = flush;
        s_rpc = rpc; s_taken = taken; s_tgt = tgt;
        tick();
    endtask

    initial begin
        nrst = 1'b0;
        s_busy = 0; s_stall = 0; s_flush = 0; s_taken = 0; s_ovr_en = 0;
        s_rpc = '0; s_tgt = '0; s_ovr = '0;
        bus.imem_busy = 0; bus.ex_stall = 0; bus.ex_flush = 0;
        bus.ex_redirect_pc = '0; bus.predict_taken = 0; bus.predict_target = '0;
        bus.imem_rdata = '0;
        model_reset();
        #12;
        compare_all();
        check("rst_ren", 32'(bus.imem_ren), 32'd0);
        nrst = 1'b1;
        #1;
        compare_all();

        // sequential fetch and predicted-taken
        drive(0, 0, 0, 0, 0, 0);
        check("seq_pc0", bus.fe_pc, 32'h200);
        check("seq_tok", 32'(bus.fe_token), 32'd1);
        drive(0, 0, 0, 0, 1, 32'h400);
        check("pred_pc", bus.fe_pc, 32'h204);
        check("pred_val", bus.fe_prediction, 32'h400);
        drive(0, 0, 0, 0, 0, 0);
        check("tgt_pc", bus.fe_pc, 32'h400);

        // stall holds the register and the PC
        drive(0, 0, 1, 32'h208, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            check("stall_pc", bus.fe_pc, 32'h208);
            check("stall_addr", bus.imem_addr, 32'h20C);
        end
        drive(0, 0, 0, 0, 0, 0);
        check("unstall_pc", bus.fe_pc, 32'h20C);

        // flush while memory busy: stale word must be dropped
        drive(1, 0, 1, 32'h800, 0, 0);
        check("fl_tok", 32'(bus.fe_token), 32'd0);
        check("fl_old_addr", bus.imem_addr, 32'h210);
        drive(1, 0, 0, 0, 0, 0);
        s_ovr_en = 1; s_ovr = 32'hDEAD_BEEF;
        drive(0, 0, 0, 0, 0, 0);
        s_ovr_en = 0;
        drive(0, 0, 0, 0, 0, 0);
        check("fl_new_pc", bus.fe_pc, 32'h800);
        check("no_deadbeef", 32'(bus.fe_instr == 32'hDEAD_BEEF), 32'd0);

        // flush beats stall
        drive(0, 1, 1, 32'h300, 0, 0);
        check("fbs_tok", 32'(bus.fe_token), 32'd0);
        check("fbs_addr", bus.imem_addr, 32'h300);

        // misaligned redirect
        drive(0, 0, 1, 32'h302, 0, 0);
        check("mis_flag", 32'(bus.fetch_misaligned), 32'd1);
        check("mis_ren", 32'(bus.imem_ren), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("mis_tok", 32'(bus.fe_token), 32'd0);

        // PC+4 wrap
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("wrap_pc", bus.fe_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", bus.fe_pc4, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        check("wrap_next", bus.fe_pc, 32'h0);

        // reset in the middle of a discard
        drive(1, 0, 1, 32'h500, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        nrst = 1'b0;
        #1;
        model_reset();
        compare_all();
        nrst = 1'b1;
        #1;
        compare_all();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] mask;
            mask = ($urandom_range(9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;
            drive(($urandom_range(3) == 0), ($urandom_range(4) == 0),
                  ($urandom_range(19) == 0), $urandom() & mask,
                  ($urandom_range(3) == 0), $urandom() & 32'hFFFF_FFFC);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
